mem_arbiter: RTL and testbench

Shared-memory arbiter for the multicore MIPS pipeline. It accepts instruction-fetch and data requests from `NCORES` datapath/cache pairs and serializes them onto the single RAM port. It also returns per-core hit pulses and load data that feed each datapath's `ihit`/`dhit`/`imemload`/`dmemload` inputs. Arbitration is round-robin across cores, with data taking priority over instruction within a core; RAM errors are retried up to a bounded count.

---
 rtl/mem_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin shared-memory arbiter. Serializes instruction and
//            data requests from NCORES cores onto one RAM port, retries RAM
//            errors up to MAX_RETRY times and returns per-core hit pulses
//            and registered load data.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int NCORES    = 2,
  parameter int MAX_RETRY = 3
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NCORES-1:0]      iREN,
  input  logic [NCORES-1:0][31:0] iaddr,
  input  logic [NCORES-1:0]      dREN,
  input  logic [NCORES-1:0]      dWEN,
  input  logic [NCORES-1:0][31:0] daddr,
  input  logic [NCORES-1:0][31:0] dstore,
  output logic [NCORES-1:0]      ihit,
  output logic [NCORES-1:0]      dhit,
  output logic [NCORES-1:0][31:0] iload,
  output logic [NCORES-1:0][31:0] dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [31:0]            ramaddr,
  output logic [31:0]            ramstore,
  input  logic [31:0]            ramload,
  input  logic [1:0]             ramstate,
  output logic                   abort
);

  localparam int PTR_W = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [1:0] c_ram_access = 2'd2;
  localparam logic [1:0] c_ram_error  = 2'd3;

  localparam logic [1:0] c_kind_i  = 2'd0;
  localparam logic [1:0] c_kind_dr = 2'd1;
  localparam logic [1:0] c_kind_dw = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [RTY_W-1:0]         retry_cnt_q, retry_cnt_d;
  logic [PTR_W-1:0]         win_q, win_d;
  logic [1:0]               kind_q, kind_d;
  logic [31:0]              ramaddr_q, ramaddr_d;
  logic [31:0]              ramstore_q, ramstore_d;
  logic                     ramren_q, ramren_d;
  logic                     ramwen_q, ramwen_d;
  logic [NCORES-1:0]        ihit_q, ihit_d;
  logic [NCORES-1:0]        dhit_q, dhit_d;
  logic [NCORES-1:0][31:0]  iload_q, iload_d;
  logic [NCORES-1:0][31:0]  dload_q, dload_d;
  logic                     abort_q, abort_d;

  logic                     sel_found;
  logic [PTR_W-1:0]         sel_core;
  logic [PTR_W-1:0]         cand;
  logic [1:0]               sel_kind;
  logic [31:0]              sel_addr;
  logic                     done;

  // Winner: first requesting core after rr_ptr; write beats read beats fetch.
  always_comb begin
    sel_found = 1'b0;
    sel_core  = '0;
    cand      = '0;
    for (int i = 1; i <= NCORES; i++) begin
      cand = PTR_W'((int'(rr_ptr_q) + i) % NCORES);
      if (!sel_found && (iREN[cand] || dREN[cand] || dWEN[cand])) begin
        sel_found = 1'b1;
        sel_core  = cand;
      end
    end
    if (dWEN[sel_core]) begin
      sel_kind = c_kind_dw;
    end else if (dREN[sel_core]) begin
      sel_kind = c_kind_dr;
    end else begin
      sel_kind = c_kind_i;
    end
    sel_addr = (sel_kind == c_kind_i) ? iaddr[sel_core] : daddr[sel_core];
  end

  // Next-state logic: grant in IDLE, hold strobes through WAIT, pulse in RESP.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    retry_cnt_d = retry_cnt_q;
    win_d       = win_q;
    kind_d      = kind_q;
    ramaddr_d   = ramaddr_q;
    ramstore_d  = ramstore_q;
    ramren_d    = 1'b0;
    ramwen_d    = 1'b0;
    ihit_d      = '0;
    dhit_d      = '0;
    iload_d     = iload_q;
    dload_d     = dload_q;
    abort_d     = abort_q;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d    = S_WAIT;
          win_d      = sel_core;
          kind_d     = sel_kind;
          ramaddr_d  = sel_addr;
          ramstore_d = dstore[sel_core];
          rr_ptr_d   = sel_core;
          ramren_d   = (sel_kind != c_kind_dw);
          ramwen_d   = (sel_kind == c_kind_dw);
        end
      end
      S_WAIT: begin
        ramren_d = ramren_q;
        ramwen_d = ramwen_q;
        if (ramstate == c_ram_access) begin
          done        = 1'b1;
          retry_cnt_d = '0;
          if (kind_q == c_kind_i) begin
            iload_d[win_q] = ramload;
          end else if (kind_q == c_kind_dr) begin
            dload_d[win_q] = ramload;
          end
        end else if (ramstate == c_ram_error) begin
          if (retry_cnt_q == RTY_W'(MAX_RETRY)) begin
            // Give up but still release the core with a hit pulse.
            done        = 1'b1;
            abort_d     = 1'b1;
            retry_cnt_d = '0;
          end else begin
            retry_cnt_d = retry_cnt_q + 1'b1;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (done) begin
      state_d  = S_RESP;
      ramren_d = 1'b0;
      ramwen_d = 1'b0;
      if (kind_q == c_kind_i) begin
        ihit_d[win_q] = 1'b1;
      end else begin
        dhit_d[win_q] = 1'b1;
      end
    end
  end

  // State and registered outputs; async reset aborts any in-flight access.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= PTR_W'(NCORES - 1);
      retry_cnt_q <= '0;
      win_q       <= '0;
      kind_q      <= c_kind_i;
      ramaddr_q   <= '0;
      ramstore_q  <= '0;
      ramren_q    <= 1'b0;
      ramwen_q    <= 1'b0;
      ihit_q      <= '0;
      dhit_q      <= '0;
      iload_q     <= '0;
      dload_q     <= '0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      retry_cnt_q <= retry_cnt_d;
      win_q       <= win_d;
      kind_q      <= kind_d;
      ramaddr_q   <= ramaddr_d;
      ramstore_q  <= ramstore_d;
      ramren_q    <= ramren_d;
      ramwen_q    <= ramwen_d;
      ihit_q      <= ihit_d;
      dhit_q      <= dhit_d;
      iload_q     <= iload_d;
      dload_q     <= dload_d;
      abort_q     <= abort_d;
    end
  end

  assign ihit     = ihit_q;
  assign dhit     = dhit_q;
  assign iload    = iload_q;
  assign dload    = dload_q;
  assign ramREN   = ramren_q;
  assign ramWEN   = ramwen_q;
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;
  assign abort    = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed self-checking bench for mem_arbiter (NCORES=2,
//            MAX_RETRY=3). Inputs change 1ns after a rising edge and outputs
//            are checked at the same point.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic             CLK;
  logic             RST;
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]       dREN;
  logic [1:0]       dWEN;
  logic [1:0][31:0] daddr;
  logic [1:0][31:0] dstore;
  logic [1:0]       ihit;
  logic [1:0]       dhit;
  logic [1:0][31:0] iload;
  logic [1:0][31:0] dload;
  logic             ramREN;
  logic             ramWEN;
  logic [31:0]      ramaddr;
  logic [31:0]      ramstore;
  logic [31:0]      ramload;
  logic [1:0]       ramstate;
  logic             abort;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  mem_arbiter #(.NCORES(2), .MAX_RETRY(3)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .abort(abort)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] f_addr [4];
  logic [1:0]  f_ihit [4];
  logic [1:0]  f_dhit [4];

  initial begin
    RST = 1'b1; iREN = '0; iaddr = '0; dREN = '0; dWEN = '0;
    daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

    // ---- reset values
    tick(); tick();
    chk("rst_ihit", 32'(ihit), 0);
    chk("rst_dhit", 32'(dhit), 0);
    chk("rst_ramREN", 32'(ramREN), 0);
    chk("rst_ramWEN", 32'(ramWEN), 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_iload0", iload[0], 0);
    chk("rst_dload1", dload[1], 0);
    chk("rst_abort", 32'(abort), 0);
    RST = 1'b0;

    // ---- single fetch, core 0
    iREN[0] = 1'b1; iaddr[0] = 32'h40;
    tick();
    chk("fetch_ramREN", 32'(ramREN), 1);
    chk("fetch_ramWEN", 32'(ramWEN), 0);
    chk("fetch_ramaddr", ramaddr, 32'h40);
    chk("fetch_nohit", 32'(ihit), 0);
    ramstate = ACCESS; ramload = 32'h8C220004;
    tick();
    chk("fetch_ihit", 32'(ihit), 32'b01);
    chk("fetch_strobe_off", 32'(ramREN), 0);
    chk("fetch_iload0", iload[0], 32'h8C220004);
    ramstate = FREE; iREN[0] = 1'b0;
    tick();
    chk("fetch_hit_gone", 32'(ihit), 0);
    chk("fetch_idle_REN", 32'(ramREN), 0);

    // ---- write over read, core 1
    dWEN[1] = 1'b1; dREN[1] = 1'b1; daddr[1] = 32'h100; dstore[1] = 32'hDEADBEEF;
    tick();
    chk("wr_ramWEN", 32'(ramWEN), 1);
    chk("wr_ramREN", 32'(ramREN), 0);
    chk("wr_ramaddr", ramaddr, 32'h100);
    chk("wr_ramstore", ramstore, 32'hDEADBEEF);
    ramstate = ACCESS; ramload = 32'h12345678;
    tick();
    chk("wr_dhit", 32'(dhit), 32'b10);
    chk("wr_ihit", 32'(ihit), 0);
    chk("wr_dload1", dload[1], 0);
    chk("wr_ramWEN_off", 32'(ramWEN), 0);
    ramstate = FREE; dWEN[1] = 1'b0; dREN[1] = 1'b0;
    tick();
    chk("wr_dhit_gone", 32'(dhit), 0);

    // ---- wait states with address change and request drop, core 0
    dREN[0] = 1'b1; daddr[0] = 32'h200;
    tick();
    chk("busy_ramREN_1", 32'(ramREN), 1);
    chk("busy_ramaddr_1", ramaddr, 32'h200);
    ramstate = BUSY; daddr[0] = 32'h999;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("busy_ramREN", 32'(ramREN), 1);
      chk("busy_ramaddr", ramaddr, 32'h200);
      chk("busy_nohit", 32'(dhit), 0);
    end
    ramstate = ACCESS; ramload = 32'hCAFEF00D; dREN[0] = 1'b0;
    tick();
    chk("busy_dhit", 32'(dhit), 32'b01);
    chk("busy_dload0", dload[0], 32'hCAFEF00D);
    ramstate = FREE;
    tick();
    chk("busy_single_pulse", 32'(dhit), 0);
    tick();
    chk("busy_no_regrant", 32'(ramREN), 0);

    // ---- two errors then access, core 1
    iREN[1] = 1'b1; iaddr[1] = 32'h80;
    tick();
    chk("retry_ramREN", 32'(ramREN), 1);
    ramstate = ERROR;
    tick();
    chk("retry_hold_1", 32'(ramREN), 1);
    tick();
    chk("retry_hold_2", 32'(ramREN), 1);
    chk("retry_nohit", 32'(ihit), 0);
    ramstate = ACCESS; ramload = 32'h11112222;
    tick();
    chk("retry_ihit", 32'(ihit), 32'b10);
    chk("retry_abort", 32'(abort), 0);
    chk("retry_iload1", iload[1], 32'h11112222);
    ramstate = FREE; iREN[1] = 1'b0;
    tick();

    // ---- four errors -> abort, core 0
    iREN[0] = 1'b1; iaddr[0] = 32'h44;
    tick();
    chk("abort_ramREN", 32'(ramREN), 1);
    ramstate = ERROR; ramload = 32'hBADBAD00;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_hold", 32'(ramREN), 1);
      chk("abort_not_yet", 32'(abort), 0);
    end
    tick();
    chk("abort_set", 32'(abort), 1);
    chk("abort_ihit", 32'(ihit), 32'b01);
    chk("abort_iload0", iload[0], 32'h8C220004);
    chk("abort_ramREN_off", 32'(ramREN), 0);
    ramstate = FREE; iREN[0] = 1'b0;
    tick(); tick();
    chk("abort_sticky", 32'(abort), 1);

    // ---- reset mid-WAIT, core 0 held
    iREN[0] = 1'b1; iaddr[0] = 32'h40;
    tick();
    chk("rstw_ramREN", 32'(ramREN), 1);
    #1 RST = 1'b1;
    #1;
    chk("rstw_strobe_drop", 32'(ramREN), 0);
    chk("rstw_abort_clr", 32'(abort), 0);
    ramstate = ACCESS;
    tick();
    chk("rstw_nohit", 32'(ihit), 0);
    ramstate = FREE; RST = 1'b0;
    tick();
    chk("rstw_regrant", 32'(ramREN), 1);
    chk("rstw_regrant_addr", ramaddr, 32'h40);
    chk("rstw_nohit2", 32'(ihit), 0);
    ramstate = ACCESS; ramload = 32'h00000055;
    tick();
    chk("rstw_ihit", 32'(ihit), 32'b01);
    chk("rstw_iload0", iload[0], 32'h55);
    ramstate = FREE; iREN[0] = 1'b0;
    tick();

    // ---- priority and fairness after a fresh reset
    RST = 1'b1;
    tick();
    RST = 1'b0;
    f_addr[0] = 32'hA00; f_dhit[0] = 2'b01; f_ihit[0] = 2'b00;
    f_addr[1] = 32'hB00; f_dhit[1] = 2'b10; f_ihit[1] = 2'b00;
    f_addr[2] = 32'hC00; f_dhit[2] = 2'b00; f_ihit[2] = 2'b01;
    f_addr[3] = 32'hD00; f_dhit[3] = 2'b00; f_ihit[3] = 2'b10;
    daddr[0] = 32'hA00; daddr[1] = 32'hB00;
    iaddr[0] = 32'hC00; iaddr[1] = 32'hD00;
    dREN = 2'b11; iREN = 2'b11;
    ramstate = ACCESS; ramload = 32'h77;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk("fair_ramREN", 32'(ramREN), 1);
      chk("fair_ramaddr", ramaddr, f_addr[g]);
      tick();
      chk("fair_dhit", 32'(dhit), 32'(f_dhit[g]));
      chk("fair_ihit", 32'(ihit), 32'(f_ihit[g]));
      dREN = dREN & ~f_dhit[g];
      iREN = iREN & ~f_ihit[g];
      tick();
    end
    tick();
    chk("fair_done_idle", 32'(ramREN), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
